// File: rtl/fft_cooley_tukey_helpers_frame_permuter.sv
// Registered lane permuter for the Cooley-Tukey FFT datapath.
// Permutes one whole frame per handshake and queues it in a small frame FIFO.
module fft_cooley_tukey_helpers_frame_permuter #(
    parameter int unsigned BIT_WIDTH = 32,
    parameter int unsigned SIZE_FFT  = 8,
    parameter int unsigned DEPTH     = 2
) (
    input  logic                                clk,
    input  logic                                reset,
    input  logic [1:0]                          cfg_mode,
    input  logic [$clog2(SIZE_FFT)-1:0]         cfg_stage,
    input  logic [SIZE_FFT-1:0][BIT_WIDTH-1:0]  recv_real,
    input  logic [SIZE_FFT-1:0][BIT_WIDTH-1:0]  recv_imaginary,
    input  logic                                recv_val,
    output logic                                recv_rdy,
    output logic [SIZE_FFT-1:0][BIT_WIDTH-1:0]  send_real,
    output logic [SIZE_FFT-1:0][BIT_WIDTH-1:0]  send_imaginary,
    output logic                                send_val,
    input  logic                                send_rdy,
    output logic [$clog2(DEPTH):0]              occupancy,
    output logic                                cfg_err
);

    localparam int unsigned L  = $clog2(SIZE_FFT);
    localparam int unsigned P  = SIZE_FFT / 2;
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned OW = PW + 1;

    typedef logic [SIZE_FFT-1:0][BIT_WIDTH-1:0] frame_t;

    typedef enum logic [1:0] {
        MODE_FRONT  = 2'd0,
        MODE_BACK   = 2'd1,
        MODE_BITREV = 2'd2,
        MODE_IDENT  = 2'd3
    } mode_e;

    function automatic logic [L-1:0] bitrev(input logic [L-1:0] k);
        logic [L-1:0] r;
        for (int unsigned i = 0; i < L; i++) begin
            r[i] = k[L-1-i];
        end
        return r;
    endfunction

    frame_t        perm_real_c;
    frame_t        perm_imag_c;
    logic          stage_err_c;
    mode_e         mode_c;
    int unsigned   stage_c;
    int unsigned   a_c;
    int unsigned   b_c;

    assign mode_c  = mode_e'(cfg_mode);
    assign stage_c = 32'(cfg_stage);

    // Input-side permutation; an out-of-range butterfly stage degrades to identity.
    always_comb begin
        perm_real_c = recv_real;
        perm_imag_c = recv_imaginary;
        stage_err_c = 1'b0;
        a_c         = 0;
        b_c         = 0;
        case (mode_c)
            MODE_FRONT, MODE_BACK: begin
                if (stage_c >= L) begin
                    stage_err_c = 1'b1;
                end else begin
                    for (int unsigned p = 0; p < P; p++) begin
                        a_c = ((p >> stage_c) << (stage_c + 32'd1)) |
                              (p & ((32'd1 << stage_c) - 32'd1));
                        b_c = a_c + (32'd1 << stage_c);
                        if (mode_c == MODE_FRONT) begin
                            perm_real_c[L'(2*p)]     = recv_real[L'(a_c)];
                            perm_real_c[L'(2*p+1)]   = recv_real[L'(b_c)];
                            perm_imag_c[L'(2*p)]     = recv_imaginary[L'(a_c)];
                            perm_imag_c[L'(2*p+1)]   = recv_imaginary[L'(b_c)];
                        end else begin
                            perm_real_c[L'(a_c)]     = recv_real[L'(2*p)];
                            perm_real_c[L'(b_c)]     = recv_real[L'(2*p+1)];
                            perm_imag_c[L'(a_c)]     = recv_imaginary[L'(2*p)];
                            perm_imag_c[L'(b_c)]     = recv_imaginary[L'(2*p+1)];
                        end
                    end
                end
            end
            MODE_BITREV: begin
                for (int unsigned k = 0; k < SIZE_FFT; k++) begin
                    perm_real_c[L'(k)] = recv_real[bitrev(L'(k))];
                    perm_imag_c[L'(k)] = recv_imaginary[bitrev(L'(k))];
                end
            end
            default: begin
                perm_real_c = recv_real;
                perm_imag_c = recv_imaginary;
            end
        endcase
    end

    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [OW-1:0] occ_q,    occ_d;
    logic          err_q,    err_d;
    logic          recv_fire_c;
    logic          send_fire_c;

    frame_t mem_real_q [DEPTH];
    frame_t mem_imag_q [DEPTH];

    assign recv_rdy    = (occ_q < OW'(DEPTH));
    assign send_val    = (occ_q != '0);
    assign recv_fire_c = recv_val && recv_rdy;
    assign send_fire_c = send_val && send_rdy;

    // Pointer, occupancy and sticky error next-state.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        occ_d    = occ_q;
        err_d    = err_q;
        if (recv_fire_c) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
            err_d    = err_q | stage_err_c;
        end
        if (send_fire_c) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({recv_fire_c, send_fire_c})
            2'b10:   occ_d = occ_q + OW'(1);
            2'b01:   occ_d = occ_q - OW'(1);
            default: occ_d = occ_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
            err_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
            err_q    <= err_d;
        end
    end

    // Frame storage is intentionally not reset; it is only observed while send_val is high.
    always_ff @(posedge clk) begin
        if (!reset && recv_fire_c) begin
            mem_real_q[wr_ptr_q] <= perm_real_c;
            mem_imag_q[wr_ptr_q] <= perm_imag_c;
        end
    end

    assign send_real      = mem_real_q[rd_ptr_q];
    assign send_imaginary = mem_imag_q[rd_ptr_q];
    assign occupancy      = occ_q;
    assign cfg_err        = err_q;

endmodule

// File: tb/tb_fft_cooley_tukey_helpers_frame_permuter.sv
// Directed, table-driven bench for the FFT frame permuter (SIZE_FFT=8, DEPTH=2).
module tb_fft_cooley_tukey_helpers_frame_permuter;

    localparam int unsigned BW = 32;
    localparam int unsigned N  = 8;
    localparam int unsigned D  = 2;

    typedef logic [N-1:0][BW-1:0] frame_t;

    typedef struct {
        logic [1:0] mode;
        logic [2:0] stage;
        int         exp_idx [N];
        string      name;
    } vec_t;

    logic         clk = 1'b0;
    logic         reset;
    logic [1:0]   cfg_mode;
    logic [2:0]   cfg_stage;
    frame_t       recv_real, recv_imaginary;
    logic         recv_val, recv_rdy;
    frame_t       send_real, send_imaginary;
    logic         send_val, send_rdy;
    logic [1:0]   occupancy;
    logic         cfg_err;

    int checks = 0;
    int errors = 0;

    fft_cooley_tukey_helpers_frame_permuter #(
        .BIT_WIDTH(BW), .SIZE_FFT(N), .DEPTH(D)
    ) dut (
        .clk(clk), .reset(reset),
        .cfg_mode(cfg_mode), .cfg_stage(cfg_stage),
        .recv_real(recv_real), .recv_imaginary(recv_imaginary),
        .recv_val(recv_val), .recv_rdy(recv_rdy),
        .send_real(send_real), .send_imaginary(send_imaginary),
        .send_val(send_val), .send_rdy(send_rdy),
        .occupancy(occupancy), .cfg_err(cfg_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    task automatic chk_frame(input string nm, input frame_t er, input frame_t ei);
        checks++;
        if (send_val !== 1'b1 || send_real !== er || send_imaginary !== ei) begin
            errors++;
            $display("FAIL %s val=%b real=%h imag=%h expected real=%h imag=%h",
                     nm, send_val, send_real, send_imaginary, er, ei);
        end
    endtask

    // Reference permutation written from the pair/index definitions.
    function automatic frame_t model(input frame_t in, input logic [1:0] mode, input int s);
        frame_t o;
        int a, b, r;
        o = in;
        if (mode == 2'd0 || mode == 2'd1) begin
            if (s < 3) begin
                for (int p = 0; p < 4; p++) begin
                    a = ((p >> s) << (s + 1)) | (p & ((1 << s) - 1));
                    b = a + (1 << s);
                    if (mode == 2'd0) begin
                        o[2*p] = in[a]; o[2*p+1] = in[b];
                    end else begin
                        o[a] = in[2*p]; o[b] = in[2*p+1];
                    end
                end
            end
        end else if (mode == 2'd2) begin
            for (int k = 0; k < 8; k++) begin
                r = ((k & 1) << 2) | (k & 2) | ((k >> 2) & 1);
                o[k] = in[r];
            end
        end
        return o;
    endfunction

    // Offer one frame with send_rdy high, then check it one cycle later.
    task automatic push_check(input string nm, input logic [1:0] m, input logic [2:0] s,
                              input frame_t ir, input frame_t ii,
                              input frame_t er, input frame_t ei);
        @(negedge clk);
        cfg_mode = m; cfg_stage = s;
        recv_real = ir; recv_imaginary = ii;
        recv_val = 1'b1; send_rdy = 1'b1;
        chk({nm, "_rdy"}, 64'(recv_rdy), 64'd1);
        @(negedge clk);
        recv_val = 1'b0;
        chk_frame(nm, er, ei);
    endtask

    vec_t   vecs [7];
    frame_t ramp_r, ramp_i, er, ei, orig_r, orig_i, mid_r, mid_i;
    frame_t bp_r [3];
    frame_t bp_i [3];
    frame_t exp_r_q [$];
    frame_t exp_i_q [$];

    initial begin
        vecs[0] = '{mode: 2'd0, stage: 3'd0, exp_idx: '{0,1,2,3,4,5,6,7}, name: "front_s0"};
        vecs[1] = '{mode: 2'd0, stage: 3'd1, exp_idx: '{0,2,1,3,4,6,5,7}, name: "front_s1"};
        vecs[2] = '{mode: 2'd0, stage: 3'd2, exp_idx: '{0,4,1,5,2,6,3,7}, name: "front_s2"};
        vecs[3] = '{mode: 2'd1, stage: 3'd1, exp_idx: '{0,2,1,3,4,6,5,7}, name: "back_s1"};
        vecs[4] = '{mode: 2'd1, stage: 3'd2, exp_idx: '{0,2,4,6,1,3,5,7}, name: "back_s2"};
        vecs[5] = '{mode: 2'd2, stage: 3'd1, exp_idx: '{0,4,2,6,1,5,3,7}, name: "bitrev"};
        vecs[6] = '{mode: 2'd3, stage: 3'd2, exp_idx: '{0,1,2,3,4,5,6,7}, name: "ident"};

        for (int k = 0; k < N; k++) begin
            ramp_r[k] = 32'(k);
            ramp_i[k] = 32'(1000 + k);
        end

        reset = 1'b1; recv_val = 1'b0; send_rdy = 1'b0;
        cfg_mode = 2'd0; cfg_stage = 3'd0; recv_real = '0; recv_imaginary = '0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        chk("rst_occ", 64'(occupancy), 64'd0);
        chk("rst_send_val", 64'(send_val), 64'd0);
        chk("rst_recv_rdy", 64'(recv_rdy), 64'd1);
        chk("rst_cfg_err", 64'(cfg_err), 64'd0);

        // Directed permutation table on the 0..7 ramp.
        for (int v = 0; v < 7; v++) begin
            for (int k = 0; k < N; k++) begin
                er[k] = 32'(vecs[v].exp_idx[k]);
                ei[k] = 32'(1000 + vecs[v].exp_idx[k]);
            end
            push_check(vecs[v].name, vecs[v].mode, vecs[v].stage, ramp_r, ramp_i, er, ei);
        end
        @(negedge clk);
        chk("table_drained", 64'(occupancy), 64'd0);
        chk("table_no_err", 64'(cfg_err), 64'd0);

        // Front followed by back at the same stage restores the original order.
        for (int s = 0; s < 3; s++) begin
            for (int k = 0; k < N; k++) begin
                orig_r[k] = $urandom;
                orig_i[k] = ~orig_r[k];
            end
            mid_r = model(orig_r, 2'd0, s);
            mid_i = model(orig_i, 2'd0, s);
            push_check("rt_front", 2'd0, 3'(s), orig_r, orig_i, mid_r, mid_i);
            push_check("rt_back", 2'd1, 3'(s), mid_r, mid_i, orig_r, orig_i);
        end

        // Backpressure: three offers into a two-entry FIFO.
        @(negedge clk);
        send_rdy = 1'b0;
        for (int f = 0; f < 3; f++) begin
            for (int k = 0; k < N; k++) begin
                bp_r[f][k] = 32'(100 * f + k);
                bp_i[f][k] = ~bp_r[f][k];
            end
        end
        for (int f = 0; f < 3; f++) begin
            if (f > 0) @(negedge clk);
            cfg_mode = 2'd3; cfg_stage = 3'd0;
            recv_real = bp_r[f]; recv_imaginary = bp_i[f]; recv_val = 1'b1;
        end
        @(negedge clk);
        recv_val = 1'b0;
        chk("bp_occ_full", 64'(occupancy), 64'd2);
        chk("bp_rdy_low", 64'(recv_rdy), 64'd0);
        chk_frame("bp_head", bp_r[0], bp_i[0]);
        @(negedge clk);
        chk_frame("bp_head_stable", bp_r[0], bp_i[0]);
        send_rdy = 1'b1;
        chk("bp_occ_2", 64'(occupancy), 64'd2);
        @(negedge clk);
        chk("bp_occ_1", 64'(occupancy), 64'd1);
        chk_frame("bp_second", bp_r[1], bp_i[1]);
        @(negedge clk);
        chk("bp_occ_0", 64'(occupancy), 64'd0);
        chk("bp_empty_val", 64'(send_val), 64'd0);

        // Sustained streaming, one frame per cycle with rotating config.
        for (int i = 0; i <= 100; i++) begin
            if (i > 0) @(negedge clk);
            if (i > 0) begin
                er = exp_r_q.pop_front();
                ei = exp_i_q.pop_front();
                chk_frame("stream_data", er, ei);
                chk("stream_occ", 64'(occupancy), 64'd1);
            end
            if (i < 100) begin
                for (int k = 0; k < N; k++) begin
                    orig_r[k] = $urandom;
                    orig_i[k] = ~orig_r[k];
                end
                cfg_mode = 2'(i % 4); cfg_stage = 3'(i % 3);
                recv_real = orig_r; recv_imaginary = orig_i; recv_val = 1'b1;
                exp_r_q.push_back(model(orig_r, 2'(i % 4), i % 3));
                exp_i_q.push_back(model(orig_i, 2'(i % 4), i % 3));
            end else begin
                recv_val = 1'b0;
            end
        end
        @(negedge clk);
        chk("stream_drained", 64'(occupancy), 64'd0);

        // Illegal stage passes through as identity and latches cfg_err.
        push_check("illegal_stage", 2'd0, 3'd3, ramp_r, ramp_i, ramp_r, ramp_i);
        chk("err_set", 64'(cfg_err), 64'd1);
        push_check("after_illegal", 2'd2, 3'd0, ramp_r, ramp_i,
                   model(ramp_r, 2'd2, 0), model(ramp_i, 2'd2, 0));
        chk("err_sticky", 64'(cfg_err), 64'd1);

        // Reset with two frames held, then accept in the deassert cycle.
        @(negedge clk);
        send_rdy = 1'b0;
        cfg_mode = 2'd3; recv_real = bp_r[0]; recv_imaginary = bp_i[0]; recv_val = 1'b1;
        repeat (2) @(negedge clk);
        recv_val = 1'b0;
        chk("pre_rst_occ", 64'(occupancy), 64'd2);
        reset = 1'b1;
        @(negedge clk);
        chk("mid_rst_occ", 64'(occupancy), 64'd0);
        chk("mid_rst_val", 64'(send_val), 64'd0);
        chk("mid_rst_err", 64'(cfg_err), 64'd0);
        chk("mid_rst_rdy", 64'(recv_rdy), 64'd1);
        reset = 1'b0;
        cfg_mode = 2'd2; cfg_stage = 3'd0;
        recv_real = ramp_r; recv_imaginary = ramp_i; recv_val = 1'b1;
        @(negedge clk);
        recv_val = 1'b0;
        chk_frame("post_rst_first", model(ramp_r, 2'd2, 0), model(ramp_i, 2'd2, 0));
        chk("post_rst_occ", 64'(occupancy), 64'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
